// File: rtl/ad53x8_stream_dac.sv
// ad53x8_stream_dac: valid/ready to SYNC_b-framed serial driver for the
// AD5308/AD5318/AD5328 octal DAC family.
// Each accepted word becomes one 16-bit MSB-first frame. DIN changes on SCLK
// rising transitions so the DAC sees stable data on every falling edge.
// After a frame SYNC_b stays high for SYNC_GAP cycles (the IDLE accept cycle
// is the last of those). In LDAC_MODE 2 an LDAC_b pulse follows a tlast word.
// Optional feature macro: AD53X8_SHADOW_EN (per-channel shadow of last code).
module ad53x8_stream_dac #(
  parameter int DAC_BITS   = 12,
  parameter int CLK_DIV    = 4,
  parameter int SYNC_GAP   = 2,
  parameter int LDAC_MODE  = 0,
  parameter int LDAC_PULSE = 2
) (
  input  logic                clkin,
  input  logic                rstn,
  output logic                SCLK,
  output logic                DIN,
  output logic                SYNC_b,
  output logic                LDAC_b,
  input  logic [15:0]         tdata,
  input  logic [2:0]          tuser,
  input  logic                tlast,
  input  logic                tvalid,
  output logic                tready,
  output logic                busy
`ifdef AD53X8_SHADOW_EN
  ,
  input  logic [2:0]          shadow_addr,
  output logic [DAC_BITS-1:0] shadow_data
`endif
);

  // Elaboration-time parameter legality checks
  if (!(DAC_BITS == 8 || DAC_BITS == 10 || DAC_BITS == 12)) begin : g_bad_dac_bits
    $error("ad53x8_stream_dac: DAC_BITS must be 8, 10 or 12");
  end
  if ((CLK_DIV < 2) || (CLK_DIV > 254) || ((CLK_DIV % 2) != 0)) begin : g_bad_clk_div
    $error("ad53x8_stream_dac: CLK_DIV must be even and within 2..254");
  end
  if ((SYNC_GAP < 1) || (SYNC_GAP > 15)) begin : g_bad_sync_gap
    $error("ad53x8_stream_dac: SYNC_GAP must be within 1..15");
  end
  if ((LDAC_MODE < 0) || (LDAC_MODE > 2)) begin : g_bad_ldac_mode
    $error("ad53x8_stream_dac: LDAC_MODE must be 0, 1 or 2");
  end
  if ((LDAC_PULSE < 1) || (LDAC_PULSE > 15)) begin : g_bad_ldac_pulse
    $error("ad53x8_stream_dac: LDAC_PULSE must be within 1..15");
  end

  // Half SCLK period minus one, in clkin cycles
  localparam logic [6:0] DIV_LAST  = 7'(CLK_DIV / 2 - 1);
  // GAP state holds SYNC_GAP-1 cycles; the IDLE cycle completes the gap
  localparam logic [3:0] GAP_LAST  = 4'(SYNC_GAP - 2);
  localparam logic [3:0] LDAC_LAST = 4'(LDAC_PULSE - 1);
  localparam logic       LDAC_IDLE = (LDAC_MODE == 1) ? 1'b0 : 1'b1;
  localparam logic       PULSE_EN  = (LDAC_MODE == 2) ? 1'b1 : 1'b0;
  localparam logic       GAP_EN    = (SYNC_GAP > 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_LDAC  = 2'd3
  } state_t;

  // Data words get {0, addr, left-justified code}; control words pass verbatim
  function automatic logic [15:0] build_frame(input logic [15:0] d, input logic [2:0] u);
    logic [11:0] code;
    logic [15:0] f;
    code = 12'(d[DAC_BITS-1:0]) << (12 - DAC_BITS);
    if (d[15]) begin
      f = d;
    end else begin
      f = {1'b0, u, code};
    end
    return f;
  endfunction

  state_t      state_r, state_nx_s;
  logic [15:0] shreg_r, shreg_nx_s;
  logic        last_r, last_nx_s;
  logic [6:0]  div_r, div_nx_s;
  logic [4:0]  bit_r, bit_nx_s;
  logic [3:0]  cnt_r, cnt_nx_s;
  logic        sclk_r, sclk_nx_s;
  logic        din_r, din_nx_s;
  logic        sync_r, sync_nx_s;
  logic        ldac_r, ldac_nx_s;
  logic        tready_r, tready_nx_s;
  logic        busy_r, busy_nx_s;
  logic [15:0] frame_s;

  assign SCLK   = sclk_r;
  assign DIN    = din_r;
  assign SYNC_b = sync_r;
  assign LDAC_b = ldac_r;
  assign tready = tready_r;
  assign busy   = busy_r;

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_nx_s  = state_r;
    shreg_nx_s  = shreg_r;
    last_nx_s   = last_r;
    div_nx_s    = div_r;
    bit_nx_s    = bit_r;
    cnt_nx_s    = cnt_r;
    sclk_nx_s   = sclk_r;
    din_nx_s    = din_r;
    sync_nx_s   = sync_r;
    ldac_nx_s   = ldac_r;
    tready_nx_s = tready_r;
    busy_nx_s   = busy_r;
    frame_s     = build_frame(tdata, tuser);
    case (state_r)
      ST_IDLE: begin
        if (tvalid && tready_r) begin
          state_nx_s  = ST_SHIFT;
          shreg_nx_s  = frame_s;
          last_nx_s   = tlast;
          div_nx_s    = 7'd0;
          bit_nx_s    = 5'd0;
          sclk_nx_s   = 1'b1;
          din_nx_s    = frame_s[15];
          sync_nx_s   = 1'b0;
          tready_nx_s = 1'b0;
          busy_nx_s   = 1'b1;
        end else begin
          tready_nx_s = 1'b1;
          busy_nx_s   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (div_r == DIV_LAST) begin
          div_nx_s = 7'd0;
          if (sclk_r) begin
            sclk_nx_s = 1'b0;
            bit_nx_s  = bit_r + 5'd1;
          end else begin
            sclk_nx_s = 1'b1;
            if (bit_r == 5'd16) begin
              // Frame complete: SCLK and SYNC_b rise together
              sync_nx_s = 1'b1;
              din_nx_s  = 1'b0;
              cnt_nx_s  = 4'd0;
              if (GAP_EN) begin
                state_nx_s = ST_GAP;
              end else if (PULSE_EN && last_r) begin
                state_nx_s = ST_LDAC;
                ldac_nx_s  = 1'b0;
              end else begin
                state_nx_s  = ST_IDLE;
                tready_nx_s = 1'b1;
                busy_nx_s   = 1'b0;
              end
            end else begin
              shreg_nx_s = {shreg_r[14:0], 1'b0};
              din_nx_s   = shreg_r[14];
            end
          end
        end else begin
          div_nx_s = div_r + 7'd1;
        end
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_nx_s = 4'd0;
          if (PULSE_EN && last_r) begin
            state_nx_s = ST_LDAC;
            ldac_nx_s  = 1'b0;
          end else begin
            state_nx_s  = ST_IDLE;
            tready_nx_s = 1'b1;
            busy_nx_s   = 1'b0;
          end
        end else begin
          cnt_nx_s = cnt_r + 4'd1;
        end
      end
      ST_LDAC: begin
        if (cnt_r == LDAC_LAST) begin
          ldac_nx_s   = 1'b1;
          state_nx_s  = ST_IDLE;
          tready_nx_s = 1'b1;
          busy_nx_s   = 1'b0;
        end else begin
          cnt_nx_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_nx_s  = ST_IDLE;
        sclk_nx_s   = 1'b1;
        din_nx_s    = 1'b0;
        sync_nx_s   = 1'b1;
        ldac_nx_s   = LDAC_IDLE;
        tready_nx_s = 1'b1;
        busy_nx_s   = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered pin outputs; reset aborts any frame
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_r  <= ST_IDLE;
      shreg_r  <= 16'h0000;
      last_r   <= 1'b0;
      div_r    <= 7'd0;
      bit_r    <= 5'd0;
      cnt_r    <= 4'd0;
      sclk_r   <= 1'b1;
      din_r    <= 1'b0;
      sync_r   <= 1'b1;
      ldac_r   <= LDAC_IDLE;
      tready_r <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      shreg_r  <= shreg_nx_s;
      last_r   <= last_nx_s;
      div_r    <= div_nx_s;
      bit_r    <= bit_nx_s;
      cnt_r    <= cnt_nx_s;
      sclk_r   <= sclk_nx_s;
      din_r    <= din_nx_s;
      sync_r   <= sync_nx_s;
      ldac_r   <= ldac_nx_s;
      tready_r <= tready_nx_s;
      busy_r   <= busy_nx_s;
    end
  end

`ifdef AD53X8_SHADOW_EN
  logic [2:0]          chan_r;
  logic [DAC_BITS-1:0] code_r;
  logic                data_r;
  logic [DAC_BITS-1:0] shadow_r [8];

  // Remember channel and code of the word being shifted out
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      chan_r <= 3'd0;
      code_r <= '0;
      data_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && (state_nx_s == ST_SHIFT)) begin
      chan_r <= tuser;
      code_r <= tdata[DAC_BITS-1:0];
      data_r <= ~tdata[15];
    end
  end

  // Commit the code to the shadow as SYNC_b rises at the end of a data frame
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) begin
        shadow_r[i] <= '0;
      end
    end else if ((state_r == ST_SHIFT) && (state_nx_s != ST_SHIFT) && data_r) begin
      shadow_r[chan_r] <= code_r;
    end
  end

  assign shadow_data = shadow_r[shadow_addr];
`endif

endmodule

// File: tb/tb_ad53x8_stream_dac.sv
// Directed self-checking bench for ad53x8_stream_dac. Three instances cover
// DAC_BITS 12/10/8, LDAC modes 2/1/0 and SYNC_GAP 2/3/1.
module tb_ad53x8_stream_dac;

  logic        clk;
  logic        rstn;
  logic [15:0] tdata;
  logic [2:0]  tuser;
  logic        tlast;
  logic        tvalid;
  logic [2:0]  shadow_addr;
  int          sel;
  int          tests;
  int          fails;

  logic sclk_a, din_a, sync_a, ldac_a, tready_a, busy_a;
  logic sclk_b, din_b, sync_b, ldac_b, tready_b, busy_b;
  logic sclk_c, din_c, sync_c, ldac_c, tready_c, busy_c;
  logic sclk_m, din_m, sync_m, ldac_m, tready_m, busy_m;
  logic tvalid_a, tvalid_b, tvalid_c;
`ifdef AD53X8_SHADOW_EN
  logic [11:0] shd_a;
  logic [9:0]  shd_b;
  logic [7:0]  shd_c;
`endif

  assign tvalid_a = tvalid && (sel == 0);
  assign tvalid_b = tvalid && (sel == 1);
  assign tvalid_c = tvalid && (sel == 2);

  ad53x8_stream_dac #(.DAC_BITS(12), .CLK_DIV(4), .SYNC_GAP(2), .LDAC_MODE(2), .LDAC_PULSE(3)) u_dut_a (
    .clkin(clk), .rstn(rstn), .SCLK(sclk_a), .DIN(din_a), .SYNC_b(sync_a), .LDAC_b(ldac_a),
    .tdata(tdata), .tuser(tuser), .tlast(tlast), .tvalid(tvalid_a), .tready(tready_a), .busy(busy_a)
`ifdef AD53X8_SHADOW_EN
    , .shadow_addr(shadow_addr), .shadow_data(shd_a)
`endif
  );

  ad53x8_stream_dac #(.DAC_BITS(10), .CLK_DIV(2), .SYNC_GAP(3), .LDAC_MODE(1), .LDAC_PULSE(2)) u_dut_b (
    .clkin(clk), .rstn(rstn), .SCLK(sclk_b), .DIN(din_b), .SYNC_b(sync_b), .LDAC_b(ldac_b),
    .tdata(tdata), .tuser(tuser), .tlast(tlast), .tvalid(tvalid_b), .tready(tready_b), .busy(busy_b)
`ifdef AD53X8_SHADOW_EN
    , .shadow_addr(shadow_addr), .shadow_data(shd_b)
`endif
  );

  ad53x8_stream_dac #(.DAC_BITS(8), .CLK_DIV(6), .SYNC_GAP(1), .LDAC_MODE(0), .LDAC_PULSE(2)) u_dut_c (
    .clkin(clk), .rstn(rstn), .SCLK(sclk_c), .DIN(din_c), .SYNC_b(sync_c), .LDAC_b(ldac_c),
    .tdata(tdata), .tuser(tuser), .tlast(tlast), .tvalid(tvalid_c), .tready(tready_c), .busy(busy_c)
`ifdef AD53X8_SHADOW_EN
    , .shadow_addr(shadow_addr), .shadow_data(shd_c)
`endif
  );

  // Route the selected instance's pins to the common observation signals
  always_comb begin
    case (sel)
      1: {sclk_m, din_m, sync_m, ldac_m, tready_m, busy_m} = {sclk_b, din_b, sync_b, ldac_b, tready_b, busy_b};
      2: {sclk_m, din_m, sync_m, ldac_m, tready_m, busy_m} = {sclk_c, din_c, sync_c, ldac_c, tready_c, busy_c};
      default: {sclk_m, din_m, sync_m, ldac_m, tready_m, busy_m} = {sclk_a, din_a, sync_a, ldac_a, tready_a, busy_a};
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Send one word, decode the frame from DIN at SCLK falling edges, and
  // measure SYNC_b low time, post-frame busy time and LDAC_b low time.
  task automatic send_word(input logic [15:0] d, input logic [2:0] u, input logic l,
                           output logic [15:0] frame, output int low_cyc, output int falls,
                           output int wait_cyc, output int ldac_low, output int nsamp,
                           output logic [4:0] first);
    int   n;
    logic prev;
    frame = 16'h0000; low_cyc = 0; falls = 0; wait_cyc = 0; ldac_low = 0; nsamp = 0;
    @(negedge clk);
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    n = 0;
    while (tready_m !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tvalid = 1'b0; tdata = 16'hFFFF; tuser = 3'd7; tlast = 1'b0;
    first = {tready_m, busy_m, sync_m, sclk_m, din_m};
    prev = 1'b1;
    n = 0;
    while (n < 3000) begin
      nsamp++;
      if (ldac_m == 1'b0) ldac_low++;
      if (sync_m == 1'b0) begin
        low_cyc++;
        if (prev && !sclk_m) begin
          falls++;
          frame = {frame[14:0], din_m};
        end
      end else if (tready_m == 1'b0) begin
        wait_cyc++;
      end else begin
        break;
      end
      prev = sclk_m;
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 3000) begin fails++; $error("FAIL frame_done_in_time: n=%0d", n); end
  endtask

  logic [15:0] fr;
  logic [4:0]  first;
  int          low_cyc, falls, wait_cyc, ldac_low, nsamp;
  int          acc, frames, hi_run, ngap, gap0, gap1, n;
  logic        had_low, prev_sync, prev_sclk;

  initial begin
    tests = 0; fails = 0;
    rstn = 1'b0; tvalid = 1'b0; tdata = 16'h0000; tuser = 3'd0; tlast = 1'b0;
    shadow_addr = 3'd0; sel = 0;
    repeat (3) @(negedge clk);

    tests++; if (sclk_m !== 1'b1) begin fails++; $error("FAIL rst_sclk: %0h", sclk_m); end
    tests++; if (din_m !== 1'b0) begin fails++; $error("FAIL rst_din: %0h", din_m); end
    tests++; if (sync_m !== 1'b1) begin fails++; $error("FAIL rst_sync: %0h", sync_m); end
    tests++; if (ldac_m !== 1'b1) begin fails++; $error("FAIL rst_ldac_mode2: %0h", ldac_m); end
    tests++; if (tready_m !== 1'b1) begin fails++; $error("FAIL rst_tready: %0h", tready_m); end
    tests++; if (busy_m !== 1'b0) begin fails++; $error("FAIL rst_busy: %0h", busy_m); end
    tests++; if (ldac_b !== 1'b0) begin fails++; $error("FAIL rst_ldac_mode1: %0h", ldac_b); end
    tests++; if (ldac_c !== 1'b1) begin fails++; $error("FAIL rst_ldac_mode0: %0h", ldac_c); end
    rstn = 1'b1;
    @(negedge clk);

    send_word(16'h02AB, 3'd5, 1'b0, fr, low_cyc, falls, wait_cyc, ldac_low, nsamp, first);
    tests++; if (first !== 5'b01010) begin fails++; $error("FAIL a_first_cycle: %0h", first); end
    tests++; if (fr !== 16'h52AB) begin fails++; $error("FAIL a_frame: %0h", fr); end
    tests++; if (low_cyc !== 64) begin fails++; $error("FAIL a_sync_low: %0d", low_cyc); end
    tests++; if (falls !== 16) begin fails++; $error("FAIL a_falls: %0d", falls); end
    tests++; if (wait_cyc !== 1) begin fails++; $error("FAIL a_gap_busy: %0d", wait_cyc); end
    tests++; if (ldac_low !== 0) begin fails++; $error("FAIL a_no_ldac: %0d", ldac_low); end
`ifdef AD53X8_SHADOW_EN
    shadow_addr = 3'd5; #1;
    tests++; if (shd_a !== 12'h2AB) begin fails++; $error("FAIL a_shadow5: %0h", shd_a); end
`endif

    send_word(16'hA003, 3'd6, 1'b0, fr, low_cyc, falls, wait_cyc, ldac_low, nsamp, first);
    tests++; if (first !== 5'b01011) begin fails++; $error("FAIL ctl_first_cycle: %0h", first); end
    tests++; if (fr !== 16'hA003) begin fails++; $error("FAIL ctl_frame: %0h", fr); end
    tests++; if (falls !== 16) begin fails++; $error("FAIL ctl_falls: %0d", falls); end
`ifdef AD53X8_SHADOW_EN
    shadow_addr = 3'd6; #1;
    tests++; if (shd_a !== 12'h000) begin fails++; $error("FAIL ctl_shadow6: %0h", shd_a); end
    shadow_addr = 3'd5; #1;
    tests++; if (shd_a !== 12'h2AB) begin fails++; $error("FAIL ctl_shadow5: %0h", shd_a); end
`endif

    send_word(16'h0FFF, 3'd1, 1'b0, fr, low_cyc, falls, wait_cyc, ldac_low, nsamp, first);
    tests++; if (fr !== 16'h1FFF) begin fails++; $error("FAIL ldac0_frame: %0h", fr); end
    tests++; if (ldac_low !== 0) begin fails++; $error("FAIL ldac0_low: %0d", ldac_low); end
    tests++; if (wait_cyc !== 1) begin fails++; $error("FAIL ldac0_busy: %0d", wait_cyc); end
    send_word(16'h0800, 3'd3, 1'b1, fr, low_cyc, falls, wait_cyc, ldac_low, nsamp, first);
    tests++; if (fr !== 16'h3800) begin fails++; $error("FAIL ldac1_frame: %0h", fr); end
    tests++; if (ldac_low !== 3) begin fails++; $error("FAIL ldac1_low: %0d", ldac_low); end
    tests++; if (wait_cyc !== 4) begin fails++; $error("FAIL ldac1_busy: %0d", wait_cyc); end

    @(negedge clk);
    tdata = 16'h0111; tuser = 3'd2; tlast = 1'b0; tvalid = 1'b1;
    acc = 0; frames = 0; hi_run = 0; ngap = 0; gap0 = -1; gap1 = -1;
    had_low = 1'b0; prev_sync = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (tvalid && acc == 3) tvalid = 1'b0;
      if (tvalid && tready_m) acc++;
      if (sync_m) begin
        hi_run++;
      end else begin
        if (prev_sync) begin
          frames++;
          if (had_low) begin
            if (ngap == 0) gap0 = hi_run;
            else gap1 = hi_run;
            ngap++;
          end
        end
        had_low = 1'b1;
        hi_run = 0;
      end
      prev_sync = sync_m;
      @(negedge clk);
    end
    tests++; if (acc !== 3) begin fails++; $error("FAIL stream_accepts: %0d", acc); end
    tests++; if (frames !== 3) begin fails++; $error("FAIL stream_frames: %0d", frames); end
    tests++; if (ngap !== 2) begin fails++; $error("FAIL stream_gaps: %0d", ngap); end
    tests++; if (gap0 !== 2) begin fails++; $error("FAIL stream_gap0: %0d", gap0); end
    tests++; if (gap1 !== 2) begin fails++; $error("FAIL stream_gap1: %0d", gap1); end

    sel = 1;
    send_word(16'h03FF, 3'd0, 1'b1, fr, low_cyc, falls, wait_cyc, ldac_low, nsamp, first);
    tests++; if (fr !== 16'h0FFC) begin fails++; $error("FAIL b_frame: %0h", fr); end
    tests++; if (low_cyc !== 32) begin fails++; $error("FAIL b_sync_low: %0d", low_cyc); end
    tests++; if (falls !== 16) begin fails++; $error("FAIL b_falls: %0d", falls); end
    tests++; if (wait_cyc !== 2) begin fails++; $error("FAIL b_gap_busy: %0d", wait_cyc); end
    tests++; if (ldac_low !== nsamp) begin fails++; $error("FAIL b_ldac_const: %0d vs %0d", ldac_low, nsamp); end

    sel = 2;
    send_word(16'h0081, 3'd7, 1'b1, fr, low_cyc, falls, wait_cyc, ldac_low, nsamp, first);
    tests++; if (fr !== 16'h7810) begin fails++; $error("FAIL c_frame: %0h", fr); end
    tests++; if (low_cyc !== 96) begin fails++; $error("FAIL c_sync_low: %0d", low_cyc); end
    tests++; if (wait_cyc !== 0) begin fails++; $error("FAIL c_gap_busy: %0d", wait_cyc); end
    tests++; if (ldac_low !== 0) begin fails++; $error("FAIL c_no_ldac: %0d", ldac_low); end
    send_word(16'h7F81, 3'd7, 1'b0, fr, low_cyc, falls, wait_cyc, ldac_low, nsamp, first);
    tests++; if (fr !== 16'h7810) begin fails++; $error("FAIL c_upper_ignored: %0h", fr); end

    sel = 0;
    @(negedge clk);
    tdata = 16'h0555; tuser = 3'd4; tlast = 1'b0; tvalid = 1'b1;
    n = 0;
    while (tready_m !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    tvalid = 1'b0;
    falls = 0; prev_sclk = 1'b1; n = 0;
    while (n < 1000) begin
      if (prev_sclk && !sclk_m) falls++;
      if (falls == 7) break;
      prev_sclk = sclk_m;
      @(negedge clk);
      n++;
    end
    tests++; if (falls !== 7) begin fails++; $error("FAIL abort_reached_fall7: %0d", falls); end
    tests++; if (sync_m !== 1'b0) begin fails++; $error("FAIL abort_mid_frame_sync: %0h", sync_m); end
    rstn = 1'b0;
    #1;
    tests++; if (sync_m !== 1'b1) begin fails++; $error("FAIL abort_sync: %0h", sync_m); end
    tests++; if (sclk_m !== 1'b1) begin fails++; $error("FAIL abort_sclk: %0h", sclk_m); end
    tests++; if (tready_m !== 1'b1) begin fails++; $error("FAIL abort_tready: %0h", tready_m); end
    tests++; if (busy_m !== 1'b0) begin fails++; $error("FAIL abort_busy: %0h", busy_m); end
`ifdef AD53X8_SHADOW_EN
    shadow_addr = 3'd5; #1;
    tests++; if (shd_a !== 12'h000) begin fails++; $error("FAIL abort_shadow_clr: %0h", shd_a); end
`endif
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_word(16'h0123, 3'd2, 1'b0, fr, low_cyc, falls, wait_cyc, ldac_low, nsamp, first);
    tests++; if (fr !== 16'h2123) begin fails++; $error("FAIL post_rst_frame: %0h", fr); end
    tests++; if (low_cyc !== 64) begin fails++; $error("FAIL post_rst_sync_low: %0d", low_cyc); end
    tests++; if (falls !== 16) begin fails++; $error("FAIL post_rst_falls: %0d", falls); end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
